// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the result bundle carried between ALU and result register.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_NOTB = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_BEQ  = 3'b110;
  localparam logic [2:0] ALU_BNE  = 3'b111;

  typedef struct packed {
    logic [31:0] f;
    logic        ovf;
    logic        zero;
  } alu_res_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU request bus plus the single result channel.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_sel;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_f;
  logic        rsp_ovf;
  logic        rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_zero
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational 8-op ALU; zero latency, no flow control.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output alu_res_t    res
);

  logic [31:0] sum;
  assign sum = a + b;

  always_comb begin
    res = '0;
    case (sel)
      ALU_ADD: begin
        res.f   = sum;
        res.ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_NOTB: res.f = ~b;
      ALU_AND:  res.f = a & b;
      ALU_OR:   res.f = a | b;
      ALU_SLT:  res.f = {31'b0, (a < b)};
      ALU_SLL:  res.f = {a[30:0], 1'b0};
      // Compare ops report only through the zero flag; f stays 0.
      ALU_BEQ:  res.zero = (a == b);
      ALU_BNE:  res.zero = (a != b);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; result registered, 1-cycle latency.
// A grant needs a free result slot (empty, or draining this cycle), so full throughput is one op/cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  logic        ptr;
  logic        slot_free;
  logic        gnt0;
  logic        gnt1;
  logic        xfer;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sel;
  alu_res_t    alu_res;

  logic        rsp_valid_q;
  logic        rsp_id_q;
  alu_res_t    rsp_q;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Grants look only at valids, slot state and the pointer; operands never feed ready.
  assign gnt0 = !rst && slot_free && bus.req0_valid && (!bus.req1_valid || !ptr);
  assign gnt1 = !rst && slot_free && bus.req1_valid && (!bus.req0_valid ||  ptr);
  assign xfer = gnt0 || gnt1;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign op_a   = gnt1 ? bus.req1_a   : bus.req0_a;
  assign op_b   = gnt1 ? bus.req1_b   : bus.req0_b;
  assign op_sel = gnt1 ? bus.req1_sel : bus.req0_sel;

  alu_core u_alu_core (
    .a   (op_a),
    .b   (op_b),
    .sel (op_sel),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_q       <= '0;
      ptr         <= RR_INIT;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt1;
      rsp_q       <= alu_res;
      // Priority passes to whoever was not served.
      ptr         <= gnt0;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_f     = rsp_q.f;
  assign bus.rsp_ovf   = rsp_q.ovf;
  assign bus.rsp_zero  = rsp_q.zero;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding priority after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  32  operands for requester n.
REQ-006 req0_sel / req1_sel  input  3  ALU opcode (000 add, 001 not-b, 010 and, 011 or, 100 slt, 101 sll-by-1, 110 beq, 111 bne).
REQ-007 req0_ready / req1_ready  output  1  grant; operation transfers when valid and ready are both high.
REQ-008 rsp_valid  output  1  result register holds an unconsumed result.
REQ-009 rsp_ready  input  1  consumer accepts result when rsp_valid and rsp_ready are both high.
REQ-010 rsp_id  output  1  index of requester that issued the held result.
REQ-011 rsp_f  output  32  registered ALU result.
REQ-012 rsp_ovf, rsp_zero  output  1  registered ALU overflow and zero flags.

Function
REQ-013 Block SHALL share one combinational ALU between two requesters and hold one result in a single-entry output register.
REQ-014 Slot free SHALL be defined as (!rsp_valid) or (rsp_valid and rsp_ready) in the same cycle.
REQ-015 At most one of req0_ready, req1_ready SHALL be high in any cycle; both SHALL be low when slot is not free.
REQ-016 When slot free and exactly one requester valid, that requester SHALL be granted.
REQ-017 When slot free and both valid, the requester matching the priority pointer SHALL be granted.
REQ-018 After each transfer the priority pointer SHALL point to the non-granted requester; without transfer it SHALL hold.
REQ-019 A continuously valid requester SHALL be granted within 2 slot-free cycles (no starvation).
REQ-020 ready SHALL depend only on valid inputs, rsp_valid, rsp_ready and state; never on operand values.
REQ-021 Latency: result of a transfer in cycle N SHALL appear on rsp_* with rsp_valid=1 in cycle N+1.
REQ-022 Simultaneous drain and transfer SHALL load the new result with rsp_valid staying 1 (full throughput, one op per cycle).
REQ-023 Drain without transfer SHALL clear rsp_valid next cycle; no drain and no transfer SHALL hold all rsp_* unchanged.
REQ-024 rsp_f SHALL be 0 for sel 110 and 111; rsp_ovf SHALL be 0 for every sel except 000.
REQ-025 Add overflow SHALL be set when a[31]==b[31] and f[31]!=a[31]; slt SHALL compare unsigned.
REQ-026 rsp_zero SHALL be 1 for sel 110 when a==b and for sel 111 when a!=b, else 0.
REQ-027 rsp_f/ovf/zero/id SHALL be stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-028 On rst: rsp_valid=0, rsp_f=0, rsp_ovf=0, rsp_zero=0, rsp_id=0, priority pointer=RR_INIT.
REQ-029 While rst high, both ready outputs SHALL be 0; no transfer occurs.
REQ-030 Reset mid-operation SHALL discard the held result without asserting rsp_valid afterwards.

Structure
REQ-031 Opcode constants (ALU_ADD..ALU_BNE) SHALL live in shared package alu_pkg.
REQ-032 The shared ALU SHALL be one sub-module instance, alu_core, purely combinational, fed by a 2:1 operand mux.
REQ-033 Arbitration and the result register SHALL be in alu_arbiter itself; no further sub-modules.

Verification
REQ-034 Req0 only, a=7, b=5, sel=000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_f=12, rsp_id=0, ovf=0.
REQ-035 Req1 a=32'h7FFFFFFF, b=1, sel=000 -> rsp_f=32'h80000000, rsp_ovf=1, rsp_id=1.
REQ-036 Both valid every cycle, rsp_ready=1, RR_INIT=0 -> grants alternate 0,1,0,1; rsp_id alternates, one result per cycle.
REQ-037 rsp_ready=0 for 3 cycles with result held -> both ready=0, rsp_* unchanged; on rsp_ready=1 same-cycle new grant occurs.
REQ-038 sel=110 a=b=9 -> rsp_zero=1, rsp_f=0; sel=111 a=9, b=9 -> rsp_zero=0, rsp_f=0.
REQ-039 rst asserted while rsp_valid=1 -> next cycle rsp_valid=0, all rsp_* 0, pointer=RR_INIT.
